segre_pipeline_ctrl: RTL

Central hazard and stall controller for the Segre 5-stage pipeline (IF, ID, EX, MEM, WB). It watches the ID-stage source registers, the EX/MEM stage memop and writeback info, branch resolution, and memory readiness. From these it drives the per-stage hold and bubble controls. ID's block input is driven from stall_id_o, and ID's NOP-injection input is driven from bubble_ex_o.

---
 rtl/segre_pipeline_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/segre_pipeline_ctrl.sv
// Hazard/stall controller for the Segre 5-stage pipeline (Mealy outputs, 3-state FSM).
// Define SEGRE_PIPE_PERF_EN to enable the saturating stall/flush performance counters.
module segre_pipeline_ctrl #(
  parameter int WORD_SIZE       = 32,
  parameter int REG_SIZE        = 5,
  parameter int LU_STALL_CYCLES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 id_valid_i,
  input  logic [REG_SIZE-1:0]  id_rs1_i,
  input  logic [REG_SIZE-1:0]  id_rs2_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic                 ex_memop_rd_i,
  input  logic                 ex_rf_we_i,
  input  logic [REG_SIZE-1:0]  ex_rf_waddr_i,
  input  logic                 br_taken_i,
  input  logic                 if_ready_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ready_i,
  output logic                 stall_if_o,
  output logic                 bubble_id_o,
  output logic                 stall_id_o,
  output logic                 bubble_ex_o,
  output logic                 stall_ex_o,
  output logic                 stall_mem_o,
  output logic [1:0]           ctrl_state_o,
  output logic [WORD_SIZE-1:0] stall_cnt_o,
  output logic [WORD_SIZE-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] LU_LOAD = 3'(LU_STALL_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;

  logic mem_wait, lu_hazard;
  logic rs1_hit, rs2_hit;

  // Outputs and transition as they would be if the controller were in RUN
  logic   run_stall_if, run_bubble_id, run_bubble_ex, run_stall_all;
  state_t run_state;
  logic [2:0] run_cnt;

  logic stall_if_c, bubble_id_c, bubble_ex_c, stall_all_c;

  assign mem_wait  = mem_req_i & ~mem_ready_i;
  assign rs1_hit   = id_use_rs1_i & (id_rs1_i == ex_rf_waddr_i);
  assign rs2_hit   = id_use_rs2_i & (id_rs2_i == ex_rf_waddr_i);
  assign lu_hazard = id_valid_i & ex_memop_rd_i & ex_rf_we_i &
                     (ex_rf_waddr_i != '0) & (rs1_hit | rs2_hit);

  always_comb begin
    run_stall_if  = 1'b0;
    run_bubble_id = 1'b0;
    run_bubble_ex = 1'b0;
    run_stall_all = 1'b0;
    run_state     = RUN;
    run_cnt       = cnt_reg;
    if (mem_wait) begin
      run_stall_all = 1'b1;
      run_state     = MEM_WAIT;
    end else if (br_taken_i) begin
      // Wrong-path ID instruction: any concurrent load-use hazard is moot
      run_bubble_id = 1'b1;
      run_bubble_ex = 1'b1;
      run_cnt       = 3'd0;
    end else if (lu_hazard) begin
      run_stall_if  = 1'b1;
      run_bubble_ex = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        run_state = LU_STALL;
        run_cnt   = LU_LOAD;
      end else begin
        run_cnt = 3'd0;
      end
    end else if (!if_ready_i) begin
      run_stall_if  = 1'b1;
      run_bubble_id = 1'b1;
    end
  end

  always_comb begin
    stall_if_c  = 1'b0;
    bubble_id_c = 1'b0;
    bubble_ex_c = 1'b0;
    stall_all_c = 1'b0;
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      RUN: begin
        stall_if_c  = run_stall_if;
        bubble_id_c = run_bubble_id;
        bubble_ex_c = run_bubble_ex;
        stall_all_c = run_stall_all;
        state_next  = run_state;
        cnt_next    = run_cnt;
      end
      LU_STALL: begin
        if (mem_wait) begin
          // The held cycle still counts as one of the load-use stall cycles
          stall_all_c = 1'b1;
          state_next  = MEM_WAIT;
          cnt_next    = (cnt_reg != 3'd0) ? cnt_reg - 3'd1 : 3'd0;
        end else if (br_taken_i) begin
          bubble_id_c = 1'b1;
          bubble_ex_c = 1'b1;
          state_next  = RUN;
          cnt_next    = 3'd0;
        end else begin
          stall_if_c  = 1'b1;
          bubble_ex_c = 1'b1;
          if (cnt_reg <= 3'd1) begin
            state_next = RUN;
            cnt_next   = 3'd0;
          end else begin
            cnt_next = cnt_reg - 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          stall_all_c = 1'b1;
        end else begin
          stall_if_c  = run_stall_if;
          bubble_id_c = run_bubble_id;
          bubble_ex_c = run_bubble_ex;
          if (br_taken_i || lu_hazard) begin
            state_next = run_state;
            cnt_next   = run_cnt;
          end else begin
            state_next = (cnt_reg != 3'd0) ? LU_STALL : RUN;
          end
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= RUN;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign stall_if_o   = ~rst_i & (stall_if_c | stall_all_c);
  assign bubble_id_o  = ~rst_i & bubble_id_c;
  assign stall_id_o   = ~rst_i & stall_all_c;
  assign bubble_ex_o  = ~rst_i & bubble_ex_c;
  assign stall_ex_o   = ~rst_i & stall_all_c;
  assign stall_mem_o  = ~rst_i & stall_all_c;
  assign ctrl_state_o = rst_i ? 2'd0 : state_reg;

`ifdef SEGRE_PIPE_PERF_EN
  logic [WORD_SIZE-1:0] stall_cnt_reg, flush_cnt_reg;
  logic                 flush_acted;

  // Only a branch flush drives both bubbles in the same cycle
  assign flush_acted = bubble_id_o & bubble_ex_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_if_o && !(&stall_cnt_reg)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_acted && !(&flush_cnt_reg)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
